// File: rtl/mole_target_ctrl.sv
// mole_target_ctrl: reaction-game round controller lighting one random target LED per round
module mole_target_ctrl #(
  parameter int NUM_LEDS = 18,
  parameter int IDX_W = $clog2(NUM_LEDS),
  parameter int SHOW_MS = 1000,
  parameter int GAP_MS = 250
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                tick_ms,
  input  logic [IDX_W-1:0]    random_value,
  input  logic [NUM_LEDS-1:0] btn,
  output logic [NUM_LEDS-1:0] leds,
  output logic                hit,
  output logic                miss,
  output logic                wrong,
  output logic [7:0]          score
);
  localparam int CNT_W = $clog2((SHOW_MS > GAP_MS ? SHOW_MS : GAP_MS) + 1);
  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] prev_idx, idx_f, idx;
  logic [NUM_LEDS-1:0] btn_q, press;
  logic last;
  // fold the random index into range, step past the previous target, detect rising presses
  always_comb begin
    idx_f = (32'(random_value) >= NUM_LEDS) ? random_value - IDX_W'(NUM_LEDS) : random_value;
    idx = (idx_f != prev_idx) ? idx_f : (32'(idx_f) == NUM_LEDS - 1) ? '0 : idx_f + IDX_W'(1);
    press = btn & ~btn_q;
    last = (32'(cnt) + 32'd1) == ((state == SHOW) ? SHOW_MS : GAP_MS);
  end
  // round state machine with registered LED, event and score outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      prev_idx <= '0;
      btn_q <= '0;
      leds <= '0;
      hit <= 1'b0;
      miss <= 1'b0;
      wrong <= 1'b0;
      score <= '0;
    end else begin
      btn_q <= btn;
      hit <= 1'b0;
      miss <= 1'b0;
      wrong <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        leds <= '0;
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= GAP;
            score <= '0;
            cnt <= '0;
          end
          GAP: if (tick_ms) begin
            if (last) begin
              state <= SHOW;
              cnt <= '0;
              prev_idx <= idx;
              leds <= NUM_LEDS'(1) << idx;
            end else cnt <= cnt + CNT_W'(1);
          end
          SHOW: begin
            if (|(press & leds)) begin
              hit <= 1'b1;
              score <= (score == 8'hff) ? score : score + 8'd1;
              leds <= '0;
              state <= GAP;
              cnt <= '0;
            end else if (|press) begin
              wrong <= 1'b1;
              leds <= '0;
              state <= GAP;
              cnt <= '0;
            end else if (tick_ms) begin
              if (last) begin
                miss <= 1'b1;
                leds <= '0;
                state <= GAP;
                cnt <= '0;
              end else cnt <= cnt + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mole_target_ctrl.sv
// tb_mole_target_ctrl: vector table plus scoreboard check of the round controller
module tb_mole_target_ctrl;
  logic clk, rst_n, enable, tick_ms;
  logic [4:0] random_value;
  logic [17:0] btn, leds;
  logic hit, miss, wrong;
  logic [7:0] score;
  typedef struct packed {
    logic [17:0] leds;
    logic h, m, w;
    logic [7:0] sc;
  } out_t;
  typedef struct {
    logic en, tk;
    logic [4:0] rv;
    logic [17:0] b;
    out_t x;
  } vec_t;
  out_t exp_q[$];
  vec_t tbl[41];
  int tests, fails;
  mole_target_ctrl #(.NUM_LEDS(18), .SHOW_MS(4), .GAP_MS(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .tick_ms(tick_ms),
    .random_value(random_value), .btn(btn), .leds(leds), .hit(hit),
    .miss(miss), .wrong(wrong), .score(score)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  function automatic out_t o(int l, bit h, bit m, bit w, int sc);
    out_t r;
    r.leds = 18'(l);
    r.h = h;
    r.m = m;
    r.w = w;
    r.sc = 8'(sc);
    return r;
  endfunction
  function automatic vec_t v(bit en, bit tk, int rv, int b, int l, bit h, bit m, bit w, int sc);
    vec_t r;
    r.en = en;
    r.tk = tk;
    r.rv = 5'(rv);
    r.b = 18'(b);
    r.x = o(l, h, m, w, sc);
    return r;
  endfunction
  task automatic check(input string nm, input out_t want);
    out_t got;
    got = {leds, hit, miss, wrong, score};
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got leds=%h hit=%b miss=%b wrong=%b score=%0d, want leds=%h hit=%b miss=%b wrong=%b score=%0d",
               nm, got.leds, got.h, got.m, got.w, got.sc, want.leds, want.h, want.m, want.w, want.sc);
    end
  endtask
  task automatic step(input logic e, input logic t, input logic [4:0] r, input logic [17:0] bb,
                      input out_t x, input string nm);
    enable = e;
    tick_ms = t;
    random_value = r;
    btn = bb;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    check(nm, exp_q.pop_front());
  endtask
  initial begin
    tests = 0;
    fails = 0;
    tbl[0]  = v(1,0,5,0,0,0,0,0,0);
    tbl[1]  = v(1,1,5,0,0,0,0,0,0);
    tbl[2]  = v(1,1,5,0,'h20,0,0,0,0);
    tbl[3]  = v(1,0,5,1<<5,0,1,0,0,1);
    tbl[4]  = v(1,0,5,0,0,0,0,0,1);
    tbl[5]  = v(1,1,20,0,0,0,0,0,1);
    tbl[6]  = v(1,1,20,0,'h4,0,0,0,1);
    tbl[7]  = v(1,1,20,0,'h4,0,0,0,1);
    tbl[8]  = v(1,1,20,0,'h4,0,0,0,1);
    tbl[9]  = v(1,1,20,0,'h4,0,0,0,1);
    tbl[10] = v(1,1,20,0,0,0,1,0,1);
    tbl[11] = v(1,0,2,0,0,0,0,0,1);
    tbl[12] = v(1,1,2,0,0,0,0,0,1);
    tbl[13] = v(1,1,2,0,'h8,0,0,0,1);
    tbl[14] = v(1,0,2,1<<9,0,0,0,1,1);
    tbl[15] = v(1,1,17,1<<9,0,0,0,0,1);
    tbl[16] = v(1,1,17,1<<9,1<<17,0,0,0,1);
    tbl[17] = v(1,0,17,0,1<<17,0,0,0,1);
    tbl[18] = v(1,0,17,1<<17,0,1,0,0,2);
    tbl[19] = v(1,1,17,1,0,0,0,0,2);
    tbl[20] = v(1,1,17,1,1,0,0,0,2);
    tbl[21] = v(1,0,17,1,1,0,0,0,2);
    tbl[22] = v(1,0,17,0,1,0,0,0,2);
    tbl[23] = v(1,0,17,1,0,1,0,0,3);
    tbl[24] = v(1,1,7,0,0,0,0,0,3);
    tbl[25] = v(1,1,7,0,'h80,0,0,0,3);
    tbl[26] = v(1,0,7,1<<3,0,0,0,1,3);
    tbl[27] = v(1,1,7,0,0,0,0,0,3);
    tbl[28] = v(1,1,7,0,'h100,0,0,0,3);
    tbl[29] = v(1,1,7,0,'h100,0,0,0,3);
    tbl[30] = v(1,1,7,0,'h100,0,0,0,3);
    tbl[31] = v(1,1,7,0,'h100,0,0,0,3);
    tbl[32] = v(1,1,7,1<<8,0,1,0,0,4);
    tbl[33] = v(1,1,10,0,0,0,0,0,4);
    tbl[34] = v(1,1,10,0,'h400,0,0,0,4);
    tbl[35] = v(1,0,10,(1<<10)|(1<<4),0,1,0,0,5);
    tbl[36] = v(1,1,12,0,0,0,0,0,5);
    tbl[37] = v(1,1,12,0,'h1000,0,0,0,5);
    tbl[38] = v(0,0,12,0,0,0,0,0,5);
    tbl[39] = v(0,1,12,1<<12,0,0,0,0,5);
    tbl[40] = v(1,0,12,0,0,0,0,0,0);
    rst_n = 1'b0;
    enable = 1'b0;
    tick_ms = 1'b0;
    random_value = '0;
    btn = '0;
    #12;
    check("reset", o(0,0,0,0,0));
    rst_n = 1'b1;
    for (int i = 0; i < 41; i++)
      step(tbl[i].en, tbl[i].tk, tbl[i].rv, tbl[i].b, tbl[i].x, $sformatf("vec%0d", i));
    for (int i = 0; i < 256; i++) begin
      int r;
      int s0;
      int s1;
      r = (i % 2 == 1) ? 3 : 4;
      s0 = (i > 255) ? 255 : i;
      s1 = (i + 1 > 255) ? 255 : i + 1;
      step(1, 1, 5'(r), '0, o(0,0,0,0,s0), $sformatf("sat%0d_gap", i));
      step(1, 1, 5'(r), '0, o(1<<r,0,0,0,s0), $sformatf("sat%0d_show", i));
      step(1, 0, 5'(r), 18'(1<<r), o(0,1,0,0,s1), $sformatf("sat%0d_hit", i));
      step(1, 0, 5'(r), '0, o(0,0,0,0,s1), $sformatf("sat%0d_idle", i));
    end
    step(1, 1, 5, '0, o(0,0,0,0,255), "pre_rst_gap");
    step(1, 1, 5, '0, o('h20,0,0,0,255), "pre_rst_show");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", o(0,0,0,0,0));
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      step(0, 1, 5'(i), 18'(1<<i), o(0,0,0,0,0), $sformatf("dark%0d", i));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mole_target_ctrl.md
# mole_target_ctrl

Round controller that consumes the LFSR random index and drives the reaction game's target LED. It spawns one lit LED per round at the index supplied by the random-number stage, then waits for the player's switch or button press or a timeout. It reports hit, miss and wrong-press events and keeps a saturating score. It sits directly downstream of the random-number stage and upstream of the score display and LED pins.

## Interface

- NUM_LEDS, 18: number of target LEDs; valid indices are 0..NUM_LEDS-1.
- IDX_W, $clog2(NUM_LEDS): width of the random index input.
- SHOW_MS, 1000: ms ticks a target stays lit before a miss.
- GAP_MS, 250: ms ticks with all LEDs dark between rounds.

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  game running; level.
- tick_ms  in  1  one-cycle strobe, once per ms.
- random_value  in  IDX_W  index from the random-number stage; free-running.
- btn  in  NUM_LEDS  debounced player inputs, active-high level.
- leds  out  NUM_LEDS  one-hot target, or all zero.
- hit  out  1  one-cycle pulse: the correct input was pressed.
- miss  out  1  one-cycle pulse: the target timed out.
- wrong  out  1  one-cycle pulse: a non-target input was pressed.
- score  out  8  hit count; saturates at 255.

## Operation

- **Reset values:** state IDLE, leds=0, hit=miss=wrong=0, score=0, tick counter=0, prev_idx=0, btn_q=0.
- **States:** IDLE, GAP, SHOW.
- **IDLE:** leds=0.
  - enable=1 moves to GAP and clears score to 0 on the same edge.
- **GAP:** leds=0. Counts tick_ms strobes.
  - On the tick that makes count equal GAP_MS, the block captures the target and moves to SHOW.
- **Target capture:** idx = random_value.
  - If idx >= NUM_LEDS, idx = idx - NUM_LEDS.
  - If idx == prev_idx, idx = (idx+1) mod NUM_LEDS.
  - The result is stored in prev_idx, and leds = 1 << idx from the next cycle.
- **SHOW:** counts tick_ms from 0.
  - **Press detection:** btn_q registers btn every cycle. A press is any bit with btn=1 and btn_q=0.
  - **Correct press** (target bit): hit pulses, score increments (saturating at 255), next state GAP.
  - **Wrong press** (any other bit, target bit not pressed): wrong pulses, next state GAP; the round ends without a score change.
  - **Timeout:** the tick_ms that makes count equal SHOW_MS pulses miss; next state GAP.
- **Precedence in one cycle:** correct press > wrong press > timeout. Only one event pulse fires per round.
- **Held inputs:** a press is edge-based. A button already high on entry to SHOW does not register until it is released and pressed again.
- **Abort:** enable=0 in any state returns to IDLE on the next edge with leds=0 and no event pulse. score holds until the next enable.
- **Reset mid-round:** all outputs return immediately (asynchronously) to their reset values.
- **Counter:** the tick counter is cleared on every state entry. Its width is $clog2(max(SHOW_MS,GAP_MS)+1).

## Timing

- **Press to outputs:** a press seen at edge N (btn high, btn_q low) produces hit/wrong high during cycle N+1. In the same cycle leds=0 and score is updated.
- **Timeout:** the qualifying tick_ms at edge N gives miss high during cycle N+1, with leds=0.
- **GAP to SHOW:** the final GAP tick at edge N gives leds one-hot during cycle N+1.
- **Event pulses:** exactly one cycle wide, mutually exclusive.
- **Latency contract:** enable rise to first lit LED is exactly GAP_MS ticks plus one cycle.

## Test plan

Parameters for all scenarios: NUM_LEDS=18, SHOW_MS=4, GAP_MS=2.

- **Reset/idle:** assert rst_n=0 mid-SHOW -> leds=0, score=0, all pulses 0 immediately; with enable=0 the outputs stay dark indefinitely.
- **Hit:** random_value=5, enable=1, 2 ticks -> leds=0x00020; pulse btn[5] -> hit for 1 cycle, score=1, leds=0 in the next cycle.
- **Capture rules:** random_value=20 -> leds bit 2 lit. Next round with random_value=2 (same as prev) -> bit 3 lit. random_value=17 after prev=17 -> bit 0 lit (wrap).
- **Timeout and wrong:** no press, 4 ticks -> miss pulse, score unchanged. Next round with target 7, press btn[3] -> wrong pulse, no hit. A btn held high across SHOW entry -> no event until re-pressed.
- **Simultaneous:** a target press on the same cycle as the 4th tick -> hit only, no miss. Target and non-target bits pressed together -> hit only.
- **Saturation and abort:** 256 consecutive hits -> score stays 255. Drop enable mid-SHOW -> leds=0 next cycle, no pulse. Re-enable -> score=0.
